// File: rtl/sdram_sim_axi.sv
// Behavioural SDRAM stand-in: AXI-style read-address/read-data burst port
// plus a backdoor write port, with a word memory whose word i starts out as i.
module sdram_sim_axi #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DP    = 262144,
  parameter int BURST = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] araddr,
  input  logic [1:0]    arburst,
  input  logic          arvalid,
  output logic          arready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rlast,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  localparam int IW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [AW-1:0] DP_A      = AW'(DP);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DP - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [IW-1:0] r_addr, w_addr_next;
  logic [1:0]    r_burst, w_burst_next;
  logic [IW-1:0] w_ar_idx;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_addr_inc;

  // Words are stored XORed with their own index, so an all-zero power-up
  // image reads back as word i == i without any per-word initialisation.
  logic [DW-1:0] r_mem [DP] = '{default: '0};

  assign w_ar_idx   = IW'(araddr % DP_A);
  assign w_wr_idx   = IW'(waddr % DP_A);
  assign w_addr_inc = (r_addr == LAST_IDX) ? '0 : r_addr + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_burst_next = r_burst;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    rdata        = '0;
    case (r_state)
      S_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          w_state_next = S_BURST;
          w_cnt_next   = '0;
          w_addr_next  = w_ar_idx;
          w_burst_next = arburst;
        end
      end
      S_BURST: begin
        rvalid = 1'b1;
        rdata  = r_mem[r_addr] ^ DW'(r_addr);
        if (r_cnt == LAST_BEAT) begin
          rlast        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          // Only FIXED (2'b00) holds the address; every other code increments.
          if (r_burst != 2'b00) begin
            w_addr_next = w_addr_inc;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_burst <= w_burst_next;
    end
  end

  // Backdoor port ignores reset so a testbench can preload during reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_wr_idx] <= wdata ^ DW'(w_wr_idx);
    end
  end

endmodule

// File: tb/tb_sdram_sim_axi.sv
// Directed bench for sdram_sim_axi: bursts of each type, address wrap,
// backdoor writes before and during bursts, reset abort, and back-to-back reads.
module tb_sdram_sim_axi;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DP    = 262144;
  localparam int BURST = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] araddr;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rlast;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] wmem [int unsigned];

  sdram_sim_axi #(.DW(DW), .AW(AW), .DP(DP), .BURST(BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rlast   (rlast),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input int unsigned ea);
    if (wmem.exists(ea)) return wmem[ea];
    return ea;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_rlast"},   32'(rlast),   32'd0);
    chk({tag, "_rdata"},   rdata,        32'd0);
  endtask

  task automatic backdoor(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    wmem[a % DP] = d;
    $display("write addr=0x%08h data=0x%08h", a, d);
  endtask

  // One read burst; optional reset at beat rst_at, optional backdoor write at beat wr_at.
  task automatic read_burst(input string name, input logic [31:0] addr, input logic [1:0] bt,
                            input int rst_at, input int wr_at,
                            input logic [31:0] wa, input logic [31:0] wd);
    int unsigned ea;
    @(negedge clk);
    araddr = addr; arburst = bt; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int k = 0; k < BURST; k++) begin
      ea = (bt == 2'b00) ? (addr % DP) : ((addr % DP) + k) % DP;
      chk($sformatf("%s_b%0d_rvalid", name, k),  32'(rvalid),  32'd1);
      chk($sformatf("%s_b%0d_rdata", name, k),   rdata,        model(ea));
      chk($sformatf("%s_b%0d_rlast", name, k),   32'(rlast),   32'(k == BURST - 1));
      chk($sformatf("%s_b%0d_arready", name, k), 32'(arready), 32'd0);
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle({name, "_abort"});
        $display("read %s addr=0x%08h burst=%0d aborted at beat %0d", name, addr, bt, k);
        return;
      end
      if (k == wr_at) begin
        we = 1'b1; waddr = wa; wdata = wd;
        wmem[wa % DP] = wd;
      end
      @(negedge clk);
      we = 1'b0;
    end
    chk_idle({name, "_end"});
    $display("read %s addr=0x%08h burst=%0d done", name, addr, bt);
  endtask

  initial begin
    int last_hs;
    int n_hs;
    bit got_idle;
    rst = 1'b1; araddr = '0; arburst = 2'b01; arvalid = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    $display("reset released");

    read_burst("incr100", 32'h100, 2'b01, -1, -1, 0, 0);
    read_burst("fixed40", 32'h40, 2'b00, -1, -1, 0, 0);
    read_burst("wrap", DP - 2, 2'b01, -1, -1, 0, 0);
    read_burst("type3", 32'h300, 2'b11, -1, -1, 0, 0);
    read_burst("alias", DP + 32'h10, 2'b01, -1, -1, 0, 0);

    backdoor(32'd5, 32'hDEADBEEF);
    read_burst("bd4", 32'd4, 2'b01, -1, -1, 0, 0);

    read_burst("later", 32'h200, 2'b01, -1, 0, 32'h205, 32'hCAFE0001);
    read_burst("current", 32'h200, 2'b01, -1, 3, 32'h203, 32'hCAFE0003);

    read_burst("rstmid", 32'h80, 2'b01, 10, -1, 0, 0);
    read_burst("after_rst", 32'h0, 2'b01, -1, -1, 0, 0);

    // arvalid during reset must not start a burst
    @(negedge clk);
    rst = 1'b1; arvalid = 1'b1; araddr = 32'h10;
    @(negedge clk);
    rst = 1'b0; arvalid = 1'b0;
    chk_idle("arv_in_rst0");
    @(negedge clk);
    chk_idle("arv_in_rst1");
    $display("arvalid during reset ignored check");

    // Continuous arvalid: handshakes every BURST+1 cycles
    arvalid = 1'b1; araddr = 32'h0; arburst = 2'b01;
    last_hs = -1; n_hs = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      chk($sformatf("cont_c%0d_rvalid", c), 32'(rvalid), 32'(!arready));
      if (arready) begin
        if (last_hs >= 0) chk($sformatf("cont_spacing_c%0d", c), 32'(c - last_hs), 32'(BURST + 1));
        last_hs = c;
        n_hs = n_hs + 1;
      end
    end
    arvalid = 1'b0;
    chk("cont_hs_count", 32'(n_hs), 32'd3);
    $display("continuous arvalid handshakes=%0d", n_hs);
    got_idle = 1'b0;
    for (int c = 0; c < 2 * BURST && !got_idle; c++) begin
      @(negedge clk);
      if (arready) got_idle = 1'b1;
    end
    chk("cont_drain_idle", 32'(got_idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_sim_axi.md
SDRAM_SIM_AXI -- requirements
Module: sdram_sim_axi

Interface
REQ-001 SHALL have parameter DW, default 32: data word width in bits.
REQ-002 SHALL have parameter AW, default 32: address width in bits.
REQ-003 SHALL have parameter DP, default 262144 (64*64*64): memory depth in words.
REQ-004 SHALL have parameter BURST, default 32: beats returned per read burst, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port araddr, input, AW bits: read start address, word-indexed.
REQ-008 SHALL have port arburst, input, 2 bits: burst type, 2'b00 FIXED, 2'b01 INCR, others treated as INCR.
REQ-009 SHALL have port arvalid, input, 1 bit: read address valid.
REQ-010 SHALL have port arready, output, 1 bit: read address ready.
REQ-011 SHALL have port rdata, output, DW bits: read data beat.
REQ-012 SHALL have port rvalid, output, 1 bit: rdata valid.
REQ-013 SHALL have port rlast, output, 1 bit: final beat of the burst.
REQ-014 SHALL have port we, input, 1 bit: backdoor write enable.
REQ-015 SHALL have port waddr, input, AW bits: backdoor write word address.
REQ-016 SHALL have port wdata, input, DW bits: backdoor write data.

Function
REQ-017 SHALL hold DP words of DW bits; at time zero, word i SHALL contain i truncated to DW bits.
REQ-018 SHALL reduce every address modulo DP before indexing memory.
REQ-019 SHALL implement a two-state FSM: IDLE and BURST.
REQ-020 In IDLE, arready SHALL be 1 and rvalid and rlast SHALL be 0.
REQ-021 In IDLE, arvalid=1 at a rising edge SHALL complete the AR handshake: latch araddr and arburst, clear the beat counter to 0, and enter BURST.
REQ-022 In BURST, arready SHALL be 0, and arvalid SHALL be ignored.
REQ-023 In BURST, rvalid SHALL be 1 every cycle; there is no rready, so the master accepts every beat.
REQ-024 The first beat SHALL appear in the cycle after the handshake edge (1-cycle latency), and beats SHALL then be back-to-back.
REQ-025 Beat k (0..BURST-1) SHALL carry mem[(addr+k) mod DP] for INCR, and mem[addr mod DP] for FIXED.
REQ-026 rlast SHALL be 1 only on beat BURST-1.
REQ-027 After beat BURST-1, the FSM SHALL return to IDLE, with arready=1 in the next cycle.
REQ-028 The minimum handshake-to-handshake spacing SHALL be BURST+1 cycles.
REQ-029 Incrementing past DP-1 SHALL wrap to word 0.
REQ-030 rdata SHALL be driven combinationally from the current beat address while rvalid=1, and SHALL be 0 while rvalid=0.
REQ-031 we=1 at a rising edge SHALL write wdata to mem[waddr mod DP] in any state, including when rst=1.
REQ-032 A backdoor write to the address of a later beat SHALL be visible on that beat; a write to the address of the current beat SHALL take effect from the next cycle.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE and clear the beat counter and latched address/burst type, giving arready=1, rvalid=0, rlast=0, rdata=0 from the next cycle.
REQ-034 rst=1 during BURST SHALL abort the burst with no further beats and no rlast.
REQ-035 Reset SHALL NOT alter memory contents.
REQ-036 arvalid asserted while rst=1 SHALL be ignored.

Verification
REQ-037 Reset then araddr=0x100, arburst=01, arvalid for 1 cycle -> next 32 cycles rdata=0x100..0x11F, rvalid=1, rlast=1 only on 0x11F, then arready=1.
REQ-038 araddr=0x40, arburst=00 -> 32 beats all 0x40.
REQ-039 araddr=DP-2, INCR -> beats DP-2, DP-1, 0, 1, ..., 29.
REQ-040 Backdoor write we=1, waddr=5, wdata=0xDEADBEEF, then INCR read at 4 -> beat 1 = 0xDEADBEEF, other beats 4 and 6..35.
REQ-041 rst pulsed at beat 10 of a burst -> next cycle rvalid=0, arready=1, with no rlast seen; a new read at 0 returns 0..31.
REQ-042 arvalid held high continuously -> handshakes exactly every 33 cycles, and arready=0 throughout each burst.
